ah_packet_splitter: RTL and testbench
=====================================

Name: ah_packet_splitter

Overview:
Wide-to-narrow packet serializer. It is the counterpart stage to the narrow-to-wide collating converter in the AH packet path.
- Accepts one IN_W-bit packet per handshake.
- Emits it as LANES = IN_W/OUT_W narrow beats, most-significant slice first. This matches the collator's {old, new} concatenation order, so splitter followed by collator is lossless.
- Valid/ready on both sides; single packet buffer; no bubble between back-to-back packets.

Parameters:
IN_W, 30, width of input packet in bits
OUT_W, 10, width of each output beat in bits
LANES, IN_W/OUT_W (derived localparam, not overridable), beats per packet; elaboration error unless IN_W % OUT_W == 0 and LANES >= 2

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
in_data  input  IN_W  wide packet
in_valid  input  1  in_data valid
in_ready  output  1  splitter can accept a packet this cycle
out_data  output  OUT_W  current narrow beat
out_valid  output  1  out_data valid
out_last  output  1  current beat is final beat of packet
out_ready  input  1  downstream accepts beat
busy  output  1  packet held (equals out_valid; status for power gating)

Behaviour:
- Interface: reset rstn, asynchronous, active-low; clock clk.
- State: full flag, lane_idx (clog2(LANES) bits), pkt register (IN_W).
- Reset values: full=0, lane_idx=0, pkt=0.
- Outputs under reset: out_valid=0, out_last=0, out_data=0, busy=0, in_ready=1.
- Input accept: in_fire = in_valid && in_ready.
- in_ready = !full || (out_fire && lane_idx==LANES-1). This is a combinational path from out_ready to in_ready and is permitted.
- Output beat: out_fire = out_valid && out_ready.
- out_valid = full.
- out_data = pkt[IN_W-1-lane_idx*OUT_W -: OUT_W]; lane 0 = MSB slice.
- out_last = full && lane_idx==LANES-1.
- Update priority per cycle:
  - in_fire: pkt<=in_data, lane_idx<=0, full<=1. This also covers the simultaneous last-beat case, giving zero bubble.
  - else out_fire && !out_last: lane_idx<=lane_idx+1.
  - else out_fire && out_last: full<=0, lane_idx<=0; pkt retained, don't-care.
  - else hold.
- Latency: packet accepted at edge N → first beat valid after edge N, i.e. visible in cycle N+1.
- Throughput: one packet per LANES cycles with out_ready held high.
- Stability: while out_valid && !out_ready, out_data and out_last must not change.
- in_valid while !in_ready: no state change; upstream holds.
- lane_idx never exceeds LANES-1; wrap only via last-beat handshake.
- Reset mid-packet: remaining beats discarded; out_valid drops asynchronously.

Decomposition:
- Shared package ah_pkt_pkg: function for lane count and clog2 index width; default width constants AH_NARROW_W=10 and AH_WIDE_W=30, shared with the collator.
- No sub-module; a single flat module with one always_ff block plus combinational assigns.

Test Plan:
- Single packet: in_data=0x2AB557FF (IN_W=30, OUT_W=10), out_ready=1 → beats 0x2AB, 0x155, 0x3FF on cycles N+1..N+3; out_last only on 0x3FF; in_ready=0 on N+1 and N+2, 1 on N+3.
- Back-to-back: two packets 0x2AB557FF then 0x00100C03 with in_valid continuously high → six consecutive beats 0x2AB,0x155,0x3FF,0x001,0x003,0x003 with no gap; second packet accepted on the cycle of beat 0x3FF.
- Backpressure: out_ready=0 for 4 cycles during beat 1 → out_data stays 0x155 and out_valid stays 1; resume yields 0x3FF next; no beat lost or duplicated.
- Blocked input: in_valid=1 with a new value while mid-packet → in_ready=0 and pkt unchanged; accepted only on the last-beat handshake.
- Reset mid-packet: assert rstn=0 after beat 0 → out_valid=0 immediately; after release in_ready=1, lane_idx=0, and the next packet starts from its MSB beat.
- Loopback: splitter feeding the collator, 100 random packets → collator output equals splitter input sequence exactly.

Source files
------------

// File: rtl/ah_pkt_pkg.sv
// Shared definitions for the AH packet path (splitter and collator).
// - AH_NARROW_W / AH_WIDE_W: default narrow beat and wide packet widths.
// - ah_lanes():  number of narrow beats per wide packet.
// - ah_idx_w():  width of a lane index register (at least 1 bit).
package ah_pkt_pkg;

    localparam int unsigned AH_NARROW_W = 10;
    localparam int unsigned AH_WIDE_W   = 30;

    function automatic int unsigned ah_lanes(input int unsigned wide_w,
                                             input int unsigned narrow_w);
        return wide_w / narrow_w;
    endfunction

    function automatic int unsigned ah_idx_w(input int unsigned lanes);
        return (lanes <= 2) ? 1 : $clog2(lanes);
    endfunction

endpackage

// File: rtl/ah_packet_splitter.sv
// Wide-to-narrow packet serializer. Holds one IN_W-bit packet and emits it as
// LANES = IN_W/OUT_W beats, most-significant slice first, so that the
// collator's {old, new} concatenation rebuilds the original packet.
// Ports:
//   clk, rstn           clock (rising edge), asynchronous active-low reset
//   in_data/valid/ready wide packet input handshake
//   out_data/valid/ready/last  narrow beat output handshake, last = final beat
//   busy                packet held (same as out_valid)
module ah_packet_splitter
    import ah_pkt_pkg::*;
#(
    parameter int unsigned IN_W  = AH_WIDE_W,
    parameter int unsigned OUT_W = AH_NARROW_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    localparam int unsigned LANES = ah_lanes(IN_W, OUT_W);
    localparam int unsigned IDX_W = ah_idx_w(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    if ((IN_W % OUT_W) != 0 || LANES < 2) begin : g_bad_widths
        $error("ah_packet_splitter: IN_W must be a multiple of OUT_W with at least 2 lanes");
    end

    logic             full;
    logic [IDX_W-1:0] lane_idx;
    logic [IN_W-1:0]  pkt;

    logic is_last_lane;
    logic in_fire;
    logic out_fire;

    assign is_last_lane = (lane_idx == LAST_IDX);
    assign out_valid    = full;
    assign busy         = full;
    assign out_last     = full && is_last_lane;
    assign out_fire     = full && out_ready;
    // Accepting on the last-beat handshake gives back-to-back packets with no bubble.
    assign in_ready     = !full || (out_fire && is_last_lane);
    assign in_fire      = in_valid && in_ready;

    // Lane 0 selects the MSB slice.
    always_comb begin
        out_data = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_idx == IDX_W'(i)) begin
                out_data = pkt[IN_W-1-i*OUT_W -: OUT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full     <= 1'b0;
            lane_idx <= '0;
            pkt      <= '0;
        end else if (in_fire) begin
            pkt      <= in_data;
            lane_idx <= '0;
            full     <= 1'b1;
        end else if (out_fire && !is_last_lane) begin
            lane_idx <= lane_idx + 1'b1;
        end else if (out_fire) begin
            full     <= 1'b0;
            lane_idx <= '0;
        end
    end

endmodule

// File: tb/tb_ah_packet_splitter.sv
module tb_ah_packet_splitter;

    localparam int unsigned IN_W  = 30;
    localparam int unsigned OUT_W = 10;

    logic             clk = 1'b0;
    logic             rstn;
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic             busy;

    int checks = 0;
    int errors = 0;

    ah_packet_splitter #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             iv;
        logic [IN_W-1:0]  id;
        logic             ordy;
        logic             e_irdy;
        logic             e_ov;
        logic [OUT_W-1:0] e_od;
        logic             e_ol;
    } vec_t;

    vec_t vecs[$];

    localparam logic [IN_W-1:0] PA = 30'h2AB557FF;
    localparam logic [IN_W-1:0] PB = 30'h00100C03;
    localparam logic [IN_W-1:0] PC = 30'h12345678;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset out_last",  {31'd0, out_last},  32'd0);
        check("reset out_data",  {22'd0, out_data},  32'd0);
        check("reset busy",      {31'd0, busy},      32'd0);
        check("reset in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [IN_W-1:0] exp_q[$];
        logic [IN_W-1:0] acc;
        logic [IN_W-1:0] expv;
        int              nb;
        int              sent;
        int              got;
        logic            pending;

        //            iv    id   ordy  irdy  ov    od       ol
        // single packet
        vecs.push_back('{1'b1, PA, 1'b1, 1'b1, 1'b0, 10'h000, 1'b0});
        vecs.push_back('{1'b0, PA, 1'b1, 1'b0, 1'b1, 10'h2AB, 1'b0});
        vecs.push_back('{1'b0, PA, 1'b1, 1'b0, 1'b1, 10'h155, 1'b0});
        vecs.push_back('{1'b0, PA, 1'b1, 1'b1, 1'b1, 10'h3FF, 1'b1});
        // back-to-back A then B, second accepted on beat 0x3FF
        vecs.push_back('{1'b1, PA, 1'b1, 1'b1, 1'b0, 10'h000, 1'b0});
        vecs.push_back('{1'b1, PB, 1'b1, 1'b0, 1'b1, 10'h2AB, 1'b0});
        vecs.push_back('{1'b1, PB, 1'b1, 1'b0, 1'b1, 10'h155, 1'b0});
        vecs.push_back('{1'b1, PB, 1'b1, 1'b1, 1'b1, 10'h3FF, 1'b1});
        vecs.push_back('{1'b0, PB, 1'b1, 1'b0, 1'b1, 10'h001, 1'b0});
        vecs.push_back('{1'b0, PB, 1'b1, 1'b0, 1'b1, 10'h003, 1'b0});
        vecs.push_back('{1'b0, PB, 1'b1, 1'b1, 1'b1, 10'h003, 1'b1});
        // backpressure on beat 1 with a blocked new packet C
        vecs.push_back('{1'b1, PA, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0});
        vecs.push_back('{1'b0, PA, 1'b1, 1'b0, 1'b1, 10'h2AB, 1'b0});
        vecs.push_back('{1'b1, PC, 1'b0, 1'b0, 1'b1, 10'h155, 1'b0});
        vecs.push_back('{1'b1, PC, 1'b0, 1'b0, 1'b1, 10'h155, 1'b0});
        vecs.push_back('{1'b1, PC, 1'b0, 1'b0, 1'b1, 10'h155, 1'b0});
        vecs.push_back('{1'b1, PC, 1'b0, 1'b0, 1'b1, 10'h155, 1'b0});
        vecs.push_back('{1'b1, PC, 1'b1, 1'b0, 1'b1, 10'h155, 1'b0});
        vecs.push_back('{1'b1, PC, 1'b1, 1'b1, 1'b1, 10'h3FF, 1'b1});
        vecs.push_back('{1'b0, PC, 1'b1, 1'b0, 1'b1, 10'h123, 1'b0});
        vecs.push_back('{1'b0, PC, 1'b1, 1'b0, 1'b1, 10'h115, 1'b0});
        vecs.push_back('{1'b0, PC, 1'b1, 1'b1, 1'b1, 10'h278, 1'b1});
        vecs.push_back('{1'b0, PC, 1'b1, 1'b1, 1'b0, 10'h000, 1'b0});

        do_reset();

        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_irdy});
            check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
            check($sformatf("vec%0d busy", i),      {31'd0, busy},      {31'd0, vecs[i].e_ov});
            check($sformatf("vec%0d out_last", i),  {31'd0, out_last},  {31'd0, vecs[i].e_ol});
            if (vecs[i].e_ov)
                check($sformatf("vec%0d out_data", i), {22'd0, out_data}, {22'd0, vecs[i].e_od});
        end

        // Reset mid-packet: beat 0 consumed, then async reset
        @(negedge clk);
        in_valid = 1'b1; in_data = PA; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rst_mid beat0", {22'd0, out_data}, 32'h2AB);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_mid out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid busy",      {31'd0, busy},      32'd0);
        check("rst_mid in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_mid out_data",  {22'd0, out_data},  32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = PB;
        #1;
        check("rst_after in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rst_after first beat", {22'd0, out_data}, 32'h001);
        check("rst_after out_valid",  {31'd0, out_valid}, 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check("rst_after drained", {31'd0, out_valid}, 32'd0);

        // Loopback through a behavioural collator
        sent = 0; got = 0; nb = 0; acc = '0; pending = 1'b0;
        for (int cyc = 0; cyc < 5000 && got < 100; cyc++) begin
            @(negedge clk);
            if (!pending) begin
                if (sent < 100 && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_data  = IN_W'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                sent++;
                pending = 1'b0;
            end else begin
                pending = in_valid;
            end
            if (out_valid && out_ready) begin
                acc = {acc[IN_W-OUT_W-1:0], out_data};
                nb++;
                if (out_last) begin
                    check("loop beats per packet", nb, 32'd3);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL loop underflow: got packet 0x%0h expected none", acc);
                    end else begin
                        expv = exp_q.pop_front();
                        if (acc !== expv) begin
                            errors++;
                            $display("FAIL loop packet %0d: got 0x%0h expected 0x%0h", got, acc, expv);
                        end
                    end
                    got++;
                    nb = 0;
                end
            end
        end
        in_valid = 1'b0;
        check("loop packets received", got, 32'd100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
